// File: rtl/rgb_to_hsv.sv
// Pipelined RGB565-to-HSV converter, one pixel per clock, fixed 8-cycle latency.
// Optional macro RGB2HSV_FLUSH_EN adds a synchronous `flush` input that drops all in-flight pixels.
module rgb_to_hsv #(
    parameter int H_WIDTH     = 10,
    parameter int GREEN_ROUND = 0
) (
    input  logic               clk,
    input  logic               rst_n,
`ifdef RGB2HSV_FLUSH_EN
    input  logic               flush,
`endif
    input  logic               in_valid,
    input  logic [4:0]         red,
    input  logic [5:0]         green,
    input  logic [4:0]         blue,
    input  logic [H_WIDTH-1:0] horiz_count_in,
    output logic               write,
    output logic [8:0]         hue,
    output logic [4:0]         saturation,
    output logic [4:0]         value,
    output logic [H_WIDTH-1:0] horiz_count
);

    // Handshake: in_valid qualifies the pixel inputs on each posedge; there is no ready,
    // so every valid pixel is accepted and emerges as a single-cycle write 8 cycles later.
    logic flush_w;
`ifdef RGB2HSV_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    // One restoring-division step: returns {quotient bit, new remainder}; divisor 0 yields bit 0.
    function automatic logic [11:0] div_step(input logic [10:0] rem, input logic [4:0] dv,
                                             input int k);
        logic [10:0] sh;
        sh = 11'(dv) << k;
        if (dv != 5'd0 && rem >= sh) div_step = {1'b1, rem - sh};
        else                         div_step = {1'b0, rem};
    endfunction

    // S0 registers
    logic               vld0_q;
    logic [4:0]         r0_q, g0_q, b0_q;
    logic [H_WIDTH-1:0] hc0_q;
    logic [5:0]         g_rnd;
    logic [4:0]         g5_d;

    always_comb begin
        g_rnd = 6'((7'(green) + 7'd1) >> 1);
        if (GREEN_ROUND != 0) g5_d = (g_rnd > 6'd31) ? 5'd31 : g_rnd[4:0];
        else                  g5_d = green[5:1];
    end

    // S1 combinational: max/min, numerators and hue sector
    logic [4:0]  mx_d, mn_d, d_d, absd_d;
    logic [1:0]  sel_d;
    logic [5:0]  diff_d;
    logic [10:0] snum_d, hnum_d;

    always_comb begin
        if (r0_q >= g0_q && r0_q >= b0_q) begin
            mx_d  = r0_q;
            sel_d = 2'd0;
        end else if (g0_q >= b0_q) begin
            mx_d  = g0_q;
            sel_d = 2'd1;
        end else begin
            mx_d  = b0_q;
            sel_d = 2'd2;
        end
        mn_d = r0_q;
        if (g0_q < mn_d) mn_d = g0_q;
        if (b0_q < mn_d) mn_d = b0_q;
        d_d = mx_d - mn_d;
        case (sel_d)
            2'd0:    diff_d = {1'b0, g0_q} - {1'b0, b0_q};
            2'd1:    diff_d = {1'b0, b0_q} - {1'b0, r0_q};
            default: diff_d = {1'b0, r0_q} - {1'b0, g0_q};
        endcase
        absd_d = diff_d[5] ? (5'd0 - diff_d[4:0]) : diff_d[4:0];
        snum_d = 11'(d_d) * 11'd31;
        hnum_d = 11'(absd_d) * 11'd60;
    end

    // Index 0 holds S1; indices 1..6 hold S2..S7, each resolving one quotient bit (MSB first).
    logic               vld_q  [0:6];
    logic [10:0]        srem_q [0:6];
    logic [10:0]        hrem_q [0:6];
    logic [5:0]         sq_q   [0:6];
    logic [5:0]         hq_q   [0:6];
    logic [4:0]         mx_q   [0:6];
    logic [4:0]         dv_q   [0:6];
    logic               neg_q  [0:6];
    logic [1:0]         sel_q  [0:6];
    logic [H_WIDTH-1:0] hc_q   [0:6];

    logic [11:0] sstep [1:6];
    logic [11:0] hstep [1:6];
    logic [10:0] srem_d [1:6];
    logic [10:0] hrem_d [1:6];
    logic [5:0]  sq_d   [1:6];
    logic [5:0]  hq_d   [1:6];

    always_comb begin
        for (int i = 1; i <= 6; i++) begin
            sstep[i]       = div_step(srem_q[i-1], mx_q[i-1], 6 - i);
            hstep[i]       = div_step(hrem_q[i-1], dv_q[i-1], 6 - i);
            srem_d[i]      = sstep[i][10:0];
            hrem_d[i]      = hstep[i][10:0];
            sq_d[i]        = sq_q[i-1];
            hq_d[i]        = hq_q[i-1];
            sq_d[i][6 - i] = sstep[i][11];
            hq_d[i][6 - i] = hstep[i][11];
        end
    end

    // S8 combinational: place the quotient within its 120-degree sector
    logic [8:0] base_d, hue_d;
    always_comb begin
        case (sel_q[6])
            2'd0:    base_d = 9'd0;
            2'd1:    base_d = 9'd120;
            default: base_d = 9'd240;
        endcase
        if (!neg_q[6])            hue_d = base_d + 9'(hq_q[6]);
        else if (sel_q[6] == 2'd0) hue_d = (hq_q[6] == 6'd0) ? 9'd0 : 9'd360 - 9'(hq_q[6]);
        else                       hue_d = base_d - 9'(hq_q[6]);
    end

    logic               write_q;
    logic [8:0]         hue_q;
    logic [4:0]         sat_q, val_q;
    logic [H_WIDTH-1:0] hc_out_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld0_q <= 1'b0;
            r0_q   <= '0;
            g0_q   <= '0;
            b0_q   <= '0;
            hc0_q  <= '0;
            for (int i = 0; i <= 6; i++) begin
                vld_q[i]  <= 1'b0;
                srem_q[i] <= '0;
                hrem_q[i] <= '0;
                sq_q[i]   <= '0;
                hq_q[i]   <= '0;
                mx_q[i]   <= '0;
                dv_q[i]   <= '0;
                neg_q[i]  <= 1'b0;
                sel_q[i]  <= '0;
                hc_q[i]   <= '0;
            end
            write_q  <= 1'b0;
            hue_q    <= '0;
            sat_q    <= '0;
            val_q    <= '0;
            hc_out_q <= '0;
        end else begin
            vld0_q <= in_valid & ~flush_w;
            r0_q   <= red;
            g0_q   <= g5_d;
            b0_q   <= blue;
            hc0_q  <= horiz_count_in;

            vld_q[0]  <= vld0_q & ~flush_w;
            srem_q[0] <= snum_d;
            hrem_q[0] <= hnum_d;
            sq_q[0]   <= '0;
            hq_q[0]   <= '0;
            mx_q[0]   <= mx_d;
            dv_q[0]   <= d_d;
            neg_q[0]  <= diff_d[5];
            sel_q[0]  <= sel_d;
            hc_q[0]   <= hc0_q;

            for (int i = 1; i <= 6; i++) begin
                vld_q[i]  <= vld_q[i-1] & ~flush_w;
                srem_q[i] <= srem_d[i];
                hrem_q[i] <= hrem_d[i];
                sq_q[i]   <= sq_d[i];
                hq_q[i]   <= hq_d[i];
                mx_q[i]   <= mx_q[i-1];
                dv_q[i]   <= dv_q[i-1];
                neg_q[i]  <= neg_q[i-1];
                sel_q[i]  <= sel_q[i-1];
                hc_q[i]   <= hc_q[i-1];
            end

            // Outputs only change on a real write so they hold across bubbles and flushes.
            write_q <= vld_q[6] & ~flush_w;
            if (vld_q[6] && !flush_w) begin
                hue_q    <= hue_d;
                sat_q    <= sq_q[6][4:0];
                val_q    <= mx_q[6];
                hc_out_q <= hc_q[6];
            end
        end
    end

    assign write       = write_q;
    assign hue         = hue_q;
    assign saturation  = sat_q;
    assign value       = val_q;
    assign horiz_count = hc_out_q;

endmodule
